if_inst_queue: RTL

- Instruction fetch queue between the instruction-memory read-data return and the ID stage.
- Buffers fetched {pc, instruction, bus-error} entries so ID and immediate generation see a stable instruction while memory latency and pipeline stalls vary.
- Supplies a canonical NOP to ID when empty or flushed.
- Absorbs branch/jump redirects by discarding all queued entries in one cycle.

---
 rtl/if_inst_queue_pkg.sv | 13 +
 rtl/if_inst_queue_if.sv | 31 +++
 rtl/if_inst_queue.sv | 84 ++++++++
 3 files changed

// File: rtl/if_inst_queue_pkg.sv
// Shared fetch-path types and constants, used by the fetch queue and the IF/ID register.
package if_inst_queue_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/if_inst_queue_if.sv
// Fetch-return / ID-side handshake bundle of the instruction fetch queue.
interface if_inst_queue_if #(
  parameter int DEPTH = 2
);

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_inst;
  logic                     in_err;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              out_inst;
  logic                     out_err;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;

  // Queue side
  modport slave (
    input  in_valid, in_pc, in_inst, in_err, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, out_err, count
  );

  // Fetch unit / ID side
  modport master (
    output in_valid, in_pc, in_inst, in_err, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, out_err, count
  );

endinterface

// File: rtl/if_inst_queue.sv
// Instruction fetch queue: flop-based FIFO of {pc, inst, err} between imem return and ID,
// presenting a NOP when empty and discarding everything on a redirect flush.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  if_inst_queue_if.slave q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  storage_q [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;

  // Handshake flags depend only on registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = q_if.in_valid && in_ready && !q_if.flush;
  assign pop       = out_valid && q_if.out_ready && !q_if.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q_if.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is left unreset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      storage_q[wr_ptr_q] <= '{pc: q_if.in_pc, inst: q_if.in_inst, err: q_if.in_err};
    end
  end

  assign head = storage_q[rd_ptr_q];

  always_comb begin
    q_if.in_ready  = in_ready;
    q_if.out_valid = out_valid;
    q_if.count     = count_q;
    q_if.out_pc    = 32'd0;
    q_if.out_inst  = NOP_INST;
    q_if.out_err   = 1'b0;
    if (out_valid) begin
      q_if.out_pc   = head.pc;
      q_if.out_inst = head.inst;
      q_if.out_err  = head.err;
    end
  end

endmodule
